uart_reg_responder: RTL and testbench
=====================================

UART_REG_RESPONDER -- requirements
Module: uart_reg_responder

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of 8-bit registers (2..256).
REQ-002 SHALL have parameter CLOCK_IN_MHZ, default 100, clock frequency used for the timeout.
REQ-003 SHALL have parameter TIMEOUT_US, default 1000, inter-byte timeout in microseconds.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rx_full  input  1  receive byte available, from the UART transceiver.
REQ-007 SHALL have port rx_data_in  input  8  received byte, valid while rx_full=1.
REQ-008 SHALL have port rx_parity_error  input  1  parity error flag of the current rx byte.
REQ-009 SHALL have port rx_stop_bit_error  input  1  stop-bit error flag of the current rx byte.
REQ-010 SHALL have port rx_rd_enable_out  output  1  one-cycle pulse that consumes the rx byte.
REQ-011 SHALL have port tx_data_out  output  8  byte to transmit.
REQ-012 SHALL have port tx_wr_enable_out  output  1  one-cycle pulse that launches tx_data_out.
REQ-013 SHALL have port tx_busy_in  input  1  transmitter busy, from the UART transceiver.
REQ-014 SHALL have port reg_bus_out  output  NUM_REGS*8  register file contents, with reg i at bits [8i+7:8i].
REQ-015 SHALL have port frame_err_out  output  1  one-cycle pulse on every NAK or timeout abort.

Function
REQ-016 Protocol SHALL be: 0x57 (W), addr, data -> reply 0x06 (ACK); 0x52 (R), addr -> reply reg[addr].
REQ-017 FSM states SHALL be IDLE, GET_ADDR, GET_DATA, EXEC, SEND, SEND_WAIT.
REQ-018 Byte consume SHALL work as follows: in IDLE, GET_ADDR or GET_DATA with rx_full=1 and guard clear, pulse rx_rd_enable_out and, in the same cycle, capture rx_data_in and both error flags.
REQ-019 A one-cycle guard SHALL follow each consume, during which rx_full is ignored.
REQ-020 IDLE transitions SHALL be: W or R -> GET_ADDR; any other opcode -> SEND with 0x15 (NAK).
REQ-021 GET_ADDR transitions SHALL be: -> GET_DATA for W; -> EXEC for R.
REQ-022 GET_DATA SHALL transition to EXEC.
REQ-023 EXEC SHALL take exactly one cycle: a W write updates reg[addr], then the FSM loads 0x06; an R loads reg[addr]; then the FSM moves to SEND.
REQ-024 If addr >= NUM_REGS, EXEC SHALL load NAK and SHALL leave the registers unchanged.
REQ-025 If any byte of a frame has a parity or stop error, the responder SHALL abort the frame after that byte, send NAK, and perform no write.
REQ-026 SEND SHALL wait for tx_busy_in=0, then pulse tx_wr_enable_out for one cycle with tx_data_out stable, then move to SEND_WAIT.
REQ-027 SEND_WAIT SHALL ignore tx_busy_in for one cycle, then return to IDLE when tx_busy_in=0.
REQ-028 tx_data_out SHALL hold its value from the load until the next load.
REQ-029 The timeout counter SHALL count cycles while in GET_ADDR or GET_DATA and SHALL clear on each consumed byte.
REQ-030 When the timeout counter reaches CLOCK_IN_MHZ*TIMEOUT_US, the FSM SHALL return to IDLE with no reply and pulse frame_err_out.
REQ-031 Bytes arriving during EXEC, SEND or SEND_WAIT SHALL stay in the receiver and be consumed in IDLE.
REQ-032 Read latency, from the cycle the addr byte is consumed to tx_wr_enable_out, SHALL be 3 cycles when tx_busy_in=0.
REQ-033 The timeout counter width SHALL be $clog2(CLOCK_IN_MHZ*TIMEOUT_US+1) and SHALL NOT wrap.

Reset
REQ-034 reset SHALL be sampled on the clk rising edge only and SHALL override all other activity in that cycle.
REQ-035 Reset SHALL set: state IDLE, all registers 0x00, tx_data_out 0x00, all pulse outputs 0, guard and timeout counter 0.
REQ-036 Reset mid-frame or mid-send SHALL discard the frame with no further pulses; a byte already launched is not recalled.

Structure
REQ-037 A shared package SHALL hold the opcode constants 0x57/0x52, the reply constants 0x06/0x15, and the FSM state enum.
REQ-038 The register file SHALL be one sub-module, uart_reg_file, with a write port, an async read port and a flattened output bus.
REQ-039 The block SHALL connect directly to uart_transceiver with 8-bit words and 1-word buffers.

Verification
REQ-040 Write/readback scenario: 57 03 A5 -> reply 06 and reg_bus_out[31:24]=A5; then 52 03 -> reply A5.
REQ-041 Bad opcode scenario: 41 -> reply 15, frame_err_out pulses once, and the next frame 52 00 replies 00.
REQ-042 Address range scenario: 57 10 FF with NUM_REGS=16 -> reply 15 and all registers remain 00.
REQ-043 Parity error scenario: parity error on the data byte of 57 01 33 -> reply 15 and reg1 remains 00.
REQ-044 Timeout scenario: 57 05 then idle for 100000 cycles -> no reply, frame_err_out pulses, FSM returns to IDLE.
REQ-045 Busy stall scenario: tx_busy_in held high for 500 cycles during SEND -> exactly one tx_wr_enable_out pulse after it drops.

Source files
------------

// File: rtl/uart_reg_responder_pkg.sv
// Shared constants and state type for the UART register responder.
package uart_reg_responder_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RPL_ACK  = 8'h06;
    localparam logic [7:0] RPL_NAK  = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        EXEC,
        SEND,
        SEND_WAIT
    } state_t;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_WRITE) || (b == OP_READ);
    endfunction

endpackage

// File: rtl/uart_reg_file.sv
// Resettable byte register file: one write port, async read port, flattened bus.
module uart_reg_file
    import uart_reg_responder_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS)
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [7:0]            wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [7:0]            rd_data,
    output logic [NUM_REGS*8-1:0] reg_bus
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [7:0] q_reg;
            always_ff @(posedge clk) begin
                if (reset)
                    q_reg <= 8'h00;
                else if (wr_en && (wr_addr == ADDR_W'(gi)))
                    q_reg <= wr_data;
            end
            assign reg_bus[gi*8 +: 8] = q_reg;
        end
    endgenerate

    // Non-power-of-two sizes leave unused address codes; they read as zero.
    always_comb begin
        rd_data = 8'h00;
        if (32'(rd_addr) < NUM_REGS)
            rd_data = reg_bus[{rd_addr, 3'b000} +: 8];
    end

endmodule

// File: rtl/uart_reg_responder.sv
// Byte-oriented register access over a UART: W addr data -> ACK, R addr -> reg value.
module uart_reg_responder
    import uart_reg_responder_pkg::*;
#(
    parameter int NUM_REGS     = 16,
    parameter int CLOCK_IN_MHZ = 100,
    parameter int TIMEOUT_US   = 1000
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_full,
    input  logic [7:0]            rx_data_in,
    input  logic                  rx_parity_error,
    input  logic                  rx_stop_bit_error,
    output logic                  rx_rd_enable_out,
    output logic [7:0]            tx_data_out,
    output logic                  tx_wr_enable_out,
    input  logic                  tx_busy_in,
    output logic [NUM_REGS*8-1:0] reg_bus_out,
    output logic                  frame_err_out
);

    localparam int LIMIT  = CLOCK_IN_MHZ * TIMEOUT_US;
    localparam int CNT_W  = $clog2(LIMIT + 1);
    localparam int ADDR_W = $clog2(NUM_REGS);

    state_t           state_reg;
    logic             guard_reg;
    logic             hold_reg;
    logic             tx_wr_en_reg;
    logic             frame_err_reg;
    logic [CNT_W-1:0] timeout_cnt_reg;
    logic [7:0]       opcode_reg;
    logic [7:0]       addr_reg;
    logic [7:0]       data_reg;
    logic [7:0]       tx_data_reg;
    logic [7:0]       rd_data;
    logic             consume;
    logic             rx_err;
    logic             addr_ok;
    logic             wr_en;

    // The consume strobe is combinational so the byte is taken in the same cycle it is acknowledged.
    assign consume = !reset && !guard_reg && rx_full &&
                     ((state_reg == IDLE) || (state_reg == GET_ADDR) || (state_reg == GET_DATA));
    assign rx_err  = rx_parity_error | rx_stop_bit_error;
    assign addr_ok = 32'(addr_reg) < NUM_REGS;
    assign wr_en   = (state_reg == EXEC) && (opcode_reg == OP_WRITE) && addr_ok;

    uart_reg_file #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_reg_file (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (addr_reg[ADDR_W-1:0]),
        .wr_data (data_reg),
        .rd_addr (addr_reg[ADDR_W-1:0]),
        .rd_data (rd_data),
        .reg_bus (reg_bus_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            guard_reg       <= 1'b0;
            hold_reg        <= 1'b0;
            tx_wr_en_reg    <= 1'b0;
            frame_err_reg   <= 1'b0;
            timeout_cnt_reg <= '0;
            opcode_reg      <= 8'h00;
            addr_reg        <= 8'h00;
            data_reg        <= 8'h00;
            tx_data_reg     <= 8'h00;
        end else begin
            guard_reg     <= consume;
            tx_wr_en_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (consume) begin
                        opcode_reg      <= rx_data_in;
                        timeout_cnt_reg <= '0;
                        if (!rx_err && is_opcode(rx_data_in)) begin
                            state_reg <= GET_ADDR;
                        end else begin
                            tx_data_reg   <= RPL_NAK;
                            frame_err_reg <= 1'b1;
                            state_reg     <= SEND;
                        end
                    end
                end
                GET_ADDR, GET_DATA: begin
                    if (consume) begin
                        timeout_cnt_reg <= '0;
                        if (state_reg == GET_ADDR)
                            addr_reg <= rx_data_in;
                        else
                            data_reg <= rx_data_in;
                        if (rx_err) begin
                            tx_data_reg   <= RPL_NAK;
                            frame_err_reg <= 1'b1;
                            state_reg     <= SEND;
                        end else if (state_reg == GET_ADDR && opcode_reg == OP_WRITE) begin
                            state_reg <= GET_DATA;
                        end else begin
                            state_reg <= EXEC;
                        end
                    end else if (timeout_cnt_reg == CNT_W'(LIMIT)) begin
                        timeout_cnt_reg <= '0;
                        frame_err_reg   <= 1'b1;
                        state_reg       <= IDLE;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + CNT_W'(1);
                    end
                end
                EXEC: begin
                    if (!addr_ok) begin
                        tx_data_reg   <= RPL_NAK;
                        frame_err_reg <= 1'b1;
                    end else if (opcode_reg == OP_WRITE) begin
                        tx_data_reg <= RPL_ACK;
                    end else begin
                        tx_data_reg <= rd_data;
                    end
                    state_reg <= SEND;
                end
                SEND: begin
                    if (!tx_busy_in) begin
                        tx_wr_en_reg <= 1'b1;
                        hold_reg     <= 1'b1;
                        state_reg    <= SEND_WAIT;
                    end
                end
                SEND_WAIT: begin
                    // The transmitter raises busy a cycle after the launch, so skip one sample.
                    if (hold_reg)
                        hold_reg <= 1'b0;
                    else if (!tx_busy_in)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rx_rd_enable_out = consume;
    assign tx_data_out      = tx_data_reg;
    assign tx_wr_enable_out = tx_wr_en_reg;
    assign frame_err_out    = frame_err_reg;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Self-checking bench: emulates the UART transceiver and predicts replies from a register model.
module tb_uart_reg_responder;

    localparam int NUM_REGS = 16;
    localparam int CLK_MHZ  = 1;
    localparam int TOUT_US  = 200;
    localparam int LIMIT    = CLK_MHZ * TOUT_US;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  rx_full = 1'b0;
    logic [7:0]            rx_data_in = 8'h00;
    logic                  rx_parity_error = 1'b0;
    logic                  rx_stop_bit_error = 1'b0;
    logic                  rx_rd_enable_out;
    logic [7:0]            tx_data_out;
    logic                  tx_wr_enable_out;
    logic                  tx_busy_in = 1'b0;
    logic [NUM_REGS*8-1:0] reg_bus_out;
    logic                  frame_err_out;

    uart_reg_responder #(
        .NUM_REGS     (NUM_REGS),
        .CLOCK_IN_MHZ (CLK_MHZ),
        .TIMEOUT_US   (TOUT_US)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .rx_full           (rx_full),
        .rx_data_in        (rx_data_in),
        .rx_parity_error   (rx_parity_error),
        .rx_stop_bit_error (rx_stop_bit_error),
        .rx_rd_enable_out  (rx_rd_enable_out),
        .tx_data_out       (tx_data_out),
        .tx_wr_enable_out  (tx_wr_enable_out),
        .tx_busy_in        (tx_busy_in),
        .reg_bus_out       (reg_bus_out),
        .frame_err_out     (frame_err_out)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Transceiver emulation state: queued rx bytes are {stop_err, parity_err, data}.
    logic [9:0] rxq[$];
    bit         pop_pending = 0;
    int         cyc = 0;
    int         rd_count = 0;
    int         tx_count = 0;
    int         ferr_count = 0;
    int         last_rd_cyc = 0;
    int         last_tx_cyc = 0;
    logic [7:0] last_tx = 8'h00;
    logic [7:0] model_regs [NUM_REGS];

    always @(negedge clk) begin
        cyc++;
        pop_pending = rx_rd_enable_out;
        if (rx_rd_enable_out) begin
            rd_count++;
            last_rd_cyc = cyc;
        end
        if (tx_wr_enable_out) begin
            tx_count++;
            last_tx = tx_data_out;
            last_tx_cyc = cyc;
        end
        if (frame_err_out)
            ferr_count++;
    end

    always @(posedge clk) begin
        #1;
        if (pop_pending && rxq.size() > 0)
            void'(rxq.pop_front());
        pop_pending = 0;
        rx_full = (rxq.size() > 0);
        if (rxq.size() > 0) begin
            rx_data_in        = rxq[0][7:0];
            rx_parity_error   = rxq[0][8];
            rx_stop_bit_error = rxq[0][9];
        end else begin
            rx_data_in        = 8'h00;
            rx_parity_error   = 1'b0;
            rx_stop_bit_error = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_bus();
        logic [127:0] b;
        b = '0;
        for (int i = 0; i < NUM_REGS; i++)
            b[i*8 +: 8] = model_regs[i];
        return b;
    endfunction

    // Expected reply comes straight from the protocol rules applied to the model registers.
    task automatic run_frame(input string tag, input int n, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input int err_pos, input bit err_stop);
        logic [7:0] bytes [3];
        logic [7:0] exp_reply;
        int         exp_ferr;
        int         sent;
        int         t;
        int         tx0;
        int         fe0;
        bit         read_ok;
        bytes[0] = b0;
        bytes[1] = b1;
        bytes[2] = b2;
        read_ok  = 0;
        sent     = (err_pos >= 0) ? err_pos + 1 : n;
        if (err_pos >= 0) begin
            exp_reply = 8'h15; exp_ferr = 1;
        end else if (b0 != 8'h57 && b0 != 8'h52) begin
            exp_reply = 8'h15; exp_ferr = 1;
        end else if (int'(b1) >= NUM_REGS) begin
            exp_reply = 8'h15; exp_ferr = 1;
        end else if (b0 == 8'h57) begin
            model_regs[b1[3:0]] = b2;
            exp_reply = 8'h06; exp_ferr = 0;
        end else begin
            exp_reply = model_regs[b1[3:0]]; exp_ferr = 0; read_ok = 1;
        end
        tx0 = tx_count;
        fe0 = ferr_count;
        for (int i = 0; i < sent; i++)
            rxq.push_back({(i == err_pos) && err_stop, (i == err_pos) && !err_stop, bytes[i]});
        t = 0;
        while (tx_count == tx0 && t < 1000) begin
            tick(1);
            t++;
        end
        tick(4);
        $display("frame %s: %0d bytes %h %h %h err@%0d -> reply %h (expect %h) ferr %0d (expect %0d)",
                 tag, sent, b0, b1, b2, err_pos, last_tx, exp_reply, ferr_count - fe0, exp_ferr);
        check({tag, " reply_arrived"}, 128'(t < 1000), 128'(1));
        check({tag, " reply_count"}, 128'(tx_count - tx0), 128'(1));
        check({tag, " reply_byte"}, 128'(last_tx), 128'(exp_reply));
        check({tag, " frame_err"}, 128'(ferr_count - fe0), 128'(exp_ferr));
        check({tag, " reg_bus"}, reg_bus_out, model_bus());
        if (read_ok && !tx_busy_in)
            check({tag, " read_latency"}, 128'(last_tx_cyc - last_rd_cyc), 128'(3));
    endtask

    initial begin
        int t;
        int tx0;
        int fe0;
        int rd0;
        int kind;
        int ep;
        logic [7:0] op;
        logic [7:0] ad;
        logic [7:0] dt;

        for (int i = 0; i < NUM_REGS; i++)
            model_regs[i] = 8'h00;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        $display("reset: bus %h tx_data %h", reg_bus_out, tx_data_out);
        check("reset reg_bus", reg_bus_out, 128'(0));
        check("reset tx_data", 128'(tx_data_out), 128'(0));
        check("reset pulses", 128'({rx_rd_enable_out, tx_wr_enable_out, frame_err_out}), 128'(0));

        run_frame("addr_range", 3, 8'h57, 8'h10, 8'hFF, -1, 0);
        check("addr_range all_zero", reg_bus_out, 128'(0));
        run_frame("write3", 3, 8'h57, 8'h03, 8'hA5, -1, 0);
        check("write3 reg3", 128'(reg_bus_out[31:24]), 128'(8'hA5));
        run_frame("read3", 2, 8'h52, 8'h03, 8'h00, -1, 0);
        run_frame("bad_op", 1, 8'h41, 8'h00, 8'h00, -1, 0);
        run_frame("read0", 2, 8'h52, 8'h00, 8'h00, -1, 0);
        run_frame("parity_data", 3, 8'h57, 8'h01, 8'h33, 2, 0);
        check("parity_data reg1", 128'(reg_bus_out[15:8]), 128'(0));

        // Timeout: a frame that stalls after the address byte must abort silently.
        tx0 = tx_count;
        fe0 = ferr_count;
        rxq.push_back({2'b00, 8'h57});
        rxq.push_back({2'b00, 8'h05});
        tick(LIMIT + 100);
        $display("timeout: tx pulses %0d ferr pulses %0d", tx_count - tx0, ferr_count - fe0);
        check("timeout no_reply", 128'(tx_count - tx0), 128'(0));
        check("timeout frame_err", 128'(ferr_count - fe0), 128'(1));
        run_frame("after_timeout", 2, 8'h52, 8'h05, 8'h00, -1, 0);

        // Busy stall: reply must wait for busy to drop, then launch once.
        tx_busy_in = 1'b1;
        tx0 = tx_count;
        rxq.push_back({2'b00, 8'h52});
        rxq.push_back({2'b00, 8'h03});
        tick(500);
        check("busy held_off", 128'(tx_count - tx0), 128'(0));
        tx_busy_in = 1'b0;
        t = 0;
        while (tx_count == tx0 && t < 100) begin
            tick(1);
            t++;
        end
        tick(20);
        $display("busy: tx pulses %0d reply %h", tx_count - tx0, last_tx);
        check("busy one_pulse", 128'(tx_count - tx0), 128'(1));
        check("busy reply", 128'(last_tx), 128'(model_regs[3]));

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            ad = 8'($urandom_range(0, 20));
            dt = 8'($urandom_range(0, 255));
            if (kind == 0) begin
                op = 8'($urandom_range(0, 255));
                while (op == 8'h57 || op == 8'h52)
                    op = 8'($urandom_range(0, 255));
                run_frame("rand_badop", 1, op, 8'h00, 8'h00, -1, 0);
            end else if (kind <= 4) begin
                ep = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : -1;
                run_frame("rand_write", 3, 8'h57, ad, dt, ep, 1'($urandom_range(0, 1)));
            end else begin
                ep = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 1)) : -1;
                run_frame("rand_read", 2, 8'h52, ad, 8'h00, ep, 1'($urandom_range(0, 1)));
            end
        end

        // Reset mid-frame: discard the frame, clear the registers, emit nothing afterwards.
        rd0 = rd_count;
        rxq.push_back({2'b00, 8'h57});
        rxq.push_back({2'b00, 8'h07});
        t = 0;
        while (rd_count < rd0 + 2 && t < 100) begin
            tick(1);
            t++;
        end
        check("midreset consumed", 128'(rd_count - rd0), 128'(2));
        reset = 1'b1;
        rxq.delete();
        tick(2);
        reset = 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
            model_regs[i] = 8'h00;
        tx0 = tx_count;
        fe0 = ferr_count;
        tick(50);
        $display("midreset: tx pulses %0d ferr pulses %0d bus %h", tx_count - tx0, ferr_count - fe0, reg_bus_out);
        check("midreset no_tx", 128'(tx_count - tx0), 128'(0));
        check("midreset no_ferr", 128'(ferr_count - fe0), 128'(0));
        check("midreset reg_bus", reg_bus_out, 128'(0));
        run_frame("after_reset", 2, 8'h52, 8'h07, 8'h00, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
